eight_bit_add_sub: RTL and testbench
====================================

// Module: eight_bit_add_sub
// PURPOSE
//   Registered two's-complement adder/subtractor, 8 bits wide by default.
//   mode selects A+B or A-B. The block reports sum, carry-out and signed overflow.
//   It is a datapath leaf: ALU-style arithmetic feeding downstream logic one cycle later.
//   The core is a ripple-carry chain of full adders, with B conditionally inverted by mode.
// PARAMETERS
//   WIDTH  8  operand and result width in bits; must be >= 2
// PORTS
//   clk              in   1      rising-edge clock (single clock domain)
//   rst              in   1      asynchronous, active-high reset
//   in_valid         in   1      operands/mode qualify this cycle
//   data0            in   WIDTH  operand A
//   data1            in   WIDTH  operand B
//   mode             in   1      0 = add (A+B), 1 = subtract (A-B)
//   out_valid        out  1      result registers hold a new result
//   final_sum        out  WIDTH  result bits [WIDTH-1:0]
//   final_carry_out  out  1      carry out of MSB; for subtract, 1 = no borrow
//   overflow         out  1      signed two's-complement overflow
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is asynchronous and active-high.
//   - Operand B path: b_eff = data1 XOR {WIDTH{mode}}. Carry-in c0 = mode.
//   - Carry chain: s[i] = a[i]^b_eff[i]^c[i];
//     c[i+1] = a[i]&b_eff[i] | c[i]&(a[i]^b_eff[i]).
//   - Carry-out: final_carry_out = c[WIDTH].
//   - Overflow: overflow = c[WIDTH] ^ c[WIDTH-1], identical for add and subtract.
//   - Reset: while rst=1 (asserted async), final_sum=0, final_carry_out=0,
//     overflow=0 and out_valid=0. Release takes effect on the next clk edge.
//   - Latency: exactly 1 cycle. Inputs sampled on rising clk when in_valid=1;
//     results appear after that edge with out_valid=1.
//   - in_valid=0 at an edge: out_valid<=0; result registers hold their previous value.
//   - No backpressure. A new operation is accepted every cycle (throughput 1/cycle).
//   - Reset mid-operation: an in-flight result is discarded; outputs go to 0 immediately.
//   - Wrap-around: results are modulo 2^WIDTH and never saturate.
//   - Adding 0 with mode=1 (A-0) yields A with carry_out=1.
//   - Combinational path contains no latches; all outputs come directly from flops.
// STRUCTURE
//   - Shared package: localparam MODE_ADD=1'b0, MODE_SUB=1'b1; default WIDTH constant.
//   - Sub-module full_adder (a, b, cin -> s, cout), instantiated WIDTH times via generate.
//   - Top level holds the B-inversion XOR, the carry/overflow taps and the output registers.
// TESTING
//   - Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately;
//     out_valid=0 until the first valid op after release.
//   - Add, no carry: 0xF0+0x0F -> sum 0xFF, cout 0, ovf 0;
//     0xCC+0x33 -> 0xFF, 0, 0.
//   - Add, wrap and overflow: 0x55+0xAB -> 0x00, cout 1, ovf 0;
//     0x01+0x7F -> 0x80, cout 0, ovf 1.
//   - Subtract: 0x00-0x00 -> 0x00, cout 1, ovf 0;
//     0xFF-0x00 -> 0xFF, cout 1, ovf 0;
//     0x41-0xC1 -> 0x80, cout 0, ovf 1.
//   - Subtract, negative operands: 0xCC-0xCC -> 0x00, cout 1, ovf 0;
//     0x41-0xFF -> 0x42, cout 0, ovf 0.
//   - Streaming: back-to-back ops, one per cycle, with an in_valid=0 gap
//     -> each result appears 1 cycle after its inputs; out_valid drops for exactly the gap cycle.

Source files
------------

// File: rtl/eight_bit_add_sub_pkg.sv
// Shared constants for the registered adder/subtractor slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package eight_bit_add_sub_pkg;

  // Operation select encoding for the mode input
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Default operand/result width; anything >= 2 is legal
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/eight_bit_add_sub_if.sv
// Operand/result bundle between an issuing block and the adder/subtractor.
// Latency: n/a (wires only).
// Backpressure: none; the slave accepts one operation every cycle.
interface eight_bit_add_sub_if
  import eight_bit_add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             mode;
  logic             out_valid;
  logic [WIDTH-1:0] final_sum;
  logic             final_carry_out;
  logic             overflow;

  // Issuer: drives operands, observes registered results
  modport master (
    output in_valid, data0, data1, mode,
    input  out_valid, final_sum, final_carry_out, overflow
  );

  // Arithmetic block: consumes operands, drives registered results
  modport slave (
    input  in_valid, data0, data1, mode,
    output out_valid, final_sum, final_carry_out, overflow
  );

endinterface

// File: rtl/eight_bit_add_sub_full_adder.sv
// One-bit full adder cell used to build the ripple-carry chain.
// Latency: purely combinational.
// Backpressure: n/a.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term shared by sum and carry
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/eight_bit_add_sub.sv
// Two's-complement add/subtract with carry-out and signed overflow, registered outputs.
// Latency: 1 cycle from an in_valid edge to out_valid/results.
// Backpressure: none; accepts a new operation every cycle, results hold when idle.
module eight_bit_add_sub
  import eight_bit_add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  eight_bit_add_sub_if.slave bus
);

  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  // Subtract is A + ~B + 1: invert B and inject the +1 as carry-in
  assign sub_sel = (bus.mode == MODE_SUB);
  assign b_eff   = bus.data1 ^ {WIDTH{sub_sel}};
  assign c[0]    = sub_sel;

  // Ripple-carry chain, LSB first
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (bus.data0[i]),
      .b    (b_eff[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  // Capture results on valid edges; idle edges drop out_valid but keep the last result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q   <= s;
        carry_q <= c[WIDTH];
        // Carry into and out of the sign bit disagree exactly on signed overflow
        ovf_q   <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.final_sum       = sum_q;
  assign bus.final_carry_out = carry_q;
  assign bus.overflow        = ovf_q;

endmodule

// File: tb/tb_eight_bit_add_sub.sv
// Directed bench for eight_bit_add_sub: hand-computed vectors, reset and streaming.
// Latency: checks each result one edge after its operands.
// Backpressure: none exercised; gaps come from in_valid=0 cycles.
module tb_eight_bit_add_sub;
  import eight_bit_add_sub_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  eight_bit_add_sub_if #(.WIDTH(8)) bus ();

  eight_bit_add_sub #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic vld, input logic [7:0] sum,
                               input logic cout, input logic ovf);
    check({tag, "_vld"},  {31'd0, bus.out_valid},       {31'd0, vld});
    check({tag, "_sum"},  {24'd0, bus.final_sum},       {24'd0, sum});
    check({tag, "_cout"}, {31'd0, bus.final_carry_out}, {31'd0, cout});
    check({tag, "_ovf"},  {31'd0, bus.overflow},        {31'd0, ovf});
  endtask

  // Present one operation for one cycle and check the result right after the edge
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic [7:0] sum, input logic cout,
                        input logic ovf);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data0    = a;
    bus.data1    = b;
    bus.mode     = m;
    @(posedge clk);
    #1;
    check_outputs(tag, 1'b1, sum, cout, ovf);
  endtask

  // One idle cycle: out_valid must drop, last result must hold
  task automatic run_gap(input string tag, input logic [7:0] sum, input logic cout,
                         input logic ovf);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data0    = 8'hA5;
    bus.data1    = 8'h5A;
    bus.mode     = MODE_SUB;
    @(posedge clk);
    #1;
    check_outputs(tag, 1'b0, sum, cout, ovf);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.data0    = 8'h00;
    bus.data1    = 8'h00;
    bus.mode     = MODE_ADD;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 8'h00, 1'b0, 1'b0);

    // Release with no valid op: outputs stay idle
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_rel", 1'b0, 8'h00, 1'b0, 1'b0);

    // Add, no carry
    run_op("add_f0_0f", 8'hF0, 8'h0F, MODE_ADD, 8'hFF, 1'b0, 1'b0);
    run_op("add_cc_33", 8'hCC, 8'h33, MODE_ADD, 8'hFF, 1'b0, 1'b0);
    // Add, wrap and overflow
    run_op("add_55_ab", 8'h55, 8'hAB, MODE_ADD, 8'h00, 1'b1, 1'b0);
    run_op("add_01_7f", 8'h01, 8'h7F, MODE_ADD, 8'h80, 1'b0, 1'b1);
    run_op("add_80_80", 8'h80, 8'h80, MODE_ADD, 8'h00, 1'b1, 1'b1);
    // Subtract
    run_op("sub_00_00", 8'h00, 8'h00, MODE_SUB, 8'h00, 1'b1, 1'b0);
    run_op("sub_ff_00", 8'hFF, 8'h00, MODE_SUB, 8'hFF, 1'b1, 1'b0);
    run_op("sub_41_c1", 8'h41, 8'hC1, MODE_SUB, 8'h80, 1'b0, 1'b1);
    run_op("sub_cc_cc", 8'hCC, 8'hCC, MODE_SUB, 8'h00, 1'b1, 1'b0);
    run_op("sub_41_ff", 8'h41, 8'hFF, MODE_SUB, 8'h42, 1'b0, 1'b0);

    // Streaming with a single idle cycle in the middle
    run_op("str0_7f_01", 8'h7F, 8'h01, MODE_SUB, 8'h7E, 1'b1, 1'b0);
    run_op("str1_10_20", 8'h10, 8'h20, MODE_ADD, 8'h30, 1'b0, 1'b0);
    run_gap("str_gap", 8'h30, 1'b0, 1'b0);
    run_op("str2_80_01", 8'h80, 8'h01, MODE_SUB, 8'h7F, 1'b1, 1'b1);
    run_op("str3_ff_01", 8'hFF, 8'h01, MODE_ADD, 8'h00, 1'b1, 1'b0);

    // Async reset mid-cycle: outputs clear without waiting for a clock edge
    run_op("pre_rst", 8'h12, 8'h34, MODE_ADD, 8'h46, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data0    = 8'h7F;
    bus.data1    = 8'h7F;
    bus.mode     = MODE_ADD;
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("after_rst", 8'h7F, 8'h7F, MODE_ADD, 8'hFE, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
